// File: rtl/fir_pkg.sv
// Shared definitions for the multicycle FIR datapath and its coefficient loader.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } fir_state_e;

    localparam int COEF_WI = 1;
    localparam int COEF_WF = 15;
    localparam int COEF_W  = COEF_WI + COEF_WF;

endpackage

// File: rtl/coef_bank.sv
// One coefficient register file: synchronous write and clear, combinational read.
module coef_bank
    import fir_pkg::*;
#(
    parameter int TAPSIZE = 3,
    parameter int W       = COEF_W,
    parameter int AW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [TAPSIZE];
    logic [W-1:0] mem_d [TAPSIZE];

    // Addresses at or beyond TAPSIZE match no entry, so writes drop and reads return 0.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = 0; i < TAPSIZE; i++) begin
                if (waddr == AW'(i)) begin
                    mem_d[i] = wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < TAPSIZE; i++) begin
            if (raddr == AW'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Ping-pong coefficient loader: fills the shadow bank from a stream and swaps
// banks only on a FIR sample boundary.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int TAPSIZE = 3,
    parameter int WI      = COEF_WI,
    parameter int WF      = COEF_WF,
    parameter int AW      = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic signed [WI+WF-1:0] coef_in,
    input  logic                 coef_valid,
    output logic                 coef_ready,
    input  logic                 coef_last,
    input  logic                 frame_sync,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [WI+WF-1:0] rd_data,
    output logic                 bank_sel,
    output logic                 swap_done,
    output logic                 load_err
);

    localparam int W = WI + WF;
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPSIZE - 1);

    fir_state_e    state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          bank_sel_q, bank_sel_d;
    logic          swap_done_q, swap_done_d;
    logic          load_err_q, load_err_d;

    logic          accept;
    logic          we0, we1;
    logic [W-1:0]  rdata0, rdata1;

    assign coef_ready = !RST && (state_q != PENDING);
    assign accept     = coef_valid && coef_ready;

    // Only the inactive bank is ever written.
    assign we0 = accept && bank_sel_q;
    assign we1 = accept && !bank_sel_q;

    coef_bank #(.TAPSIZE(TAPSIZE), .W(W), .AW(AW)) u_bank0 (
        .clk   (CLK),
        .rst   (RST),
        .we    (we0),
        .waddr (wcnt_q),
        .wdata (coef_in),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    coef_bank #(.TAPSIZE(TAPSIZE), .W(W), .AW(AW)) u_bank1 (
        .clk   (CLK),
        .rst   (RST),
        .we    (we1),
        .waddr (wcnt_q),
        .wdata (coef_in),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign rd_data   = bank_sel_q ? rdata1 : rdata0;
    assign bank_sel  = bank_sel_q;
    assign swap_done = swap_done_q;
    assign load_err  = load_err_q;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        bank_sel_d  = bank_sel_q;
        swap_done_d = 1'b0;
        load_err_d  = load_err_q;

        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (coef_last) begin
                        if (wcnt_q == LAST_IDX) begin
                            state_d = PENDING;
                        end else begin
                            load_err_d = 1'b1;
                            wcnt_d     = '0;
                            state_d    = IDLE;
                        end
                    end else if (wcnt_q == LAST_IDX) begin
                        load_err_d = 1'b1;
                        wcnt_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            PENDING: begin
                if (frame_sync) begin
                    bank_sel_d  = !bank_sel_q;
                    swap_done_d = 1'b1;
                    wcnt_d      = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            bank_sel_q  <= 1'b0;
            swap_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            bank_sel_q  <= bank_sel_d;
            swap_done_q <= swap_done_d;
            load_err_q  <= load_err_d;
        end
    end

endmodule
